collatz_engine: RTL and testbench



---
 rtl/collatz_pkg.sv | 22 ++
 rtl/collatz_step.sv | 36 +++
 rtl/collatz_engine.sv | 123 ++++++++++++
 tb/tb_collatz_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types for the Collatz engine: FSM states, termination causes
// and the per-iteration step increments.
package collatz_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Also used by the wrapper to pack the status word.
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_ONE  = 3'd1,
        CAUSE_OVF  = 3'd2,
        CAUSE_TMO  = 3'd3,
        CAUSE_ERR  = 3'd4
    } cause_t;

    localparam logic [1:0] INC_PLAIN = 2'd1;
    localparam logic [1:0] INC_SHORT = 2'd2;

endpackage

// File: rtl/collatz_step.sv
// collatz_step: combinational single Collatz iteration.
// Ports: i_x (current value), o_next (next value, low WIDTH bits),
//        o_inc (steps this iteration represents), o_ovf (next needs > WIDTH bits).
// Macro COLLATZ_SHORTCUT_EN: odd x maps to (3x+1)>>1 with an increment of 2.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_next,
    output logic [1:0]       o_inc,
    output logic             o_ovf
);

    // Two guard bits hold 3x+1 for any WIDTH-bit x.
    logic [WIDTH+1:0] w_wide;
    logic [WIDTH+1:0] w_odd;
    logic [WIDTH+1:0] w_val;

    assign w_wide = {2'b00, i_x};
    assign w_odd  = (w_wide << 1) + w_wide + (WIDTH+2)'(1);

`ifdef COLLATZ_SHORTCUT_EN
    // 3x+1 is always even for odd x, so halve it in the same cycle.
    assign w_val = i_x[0] ? (w_odd >> 1) : (w_wide >> 1);
    assign o_inc = i_x[0] ? INC_SHORT : INC_PLAIN;
`else
    assign w_val = i_x[0] ? w_odd : (w_wide >> 1);
    assign o_inc = INC_PLAIN;
`endif

    assign o_next = w_val[WIDTH-1:0];
    assign o_ovf  = |w_val[WIDTH+1:WIDTH];

endmodule

// File: rtl/collatz_engine.sv
// collatz_engine: iterates the Collatz map on a seed, one iteration per clock,
// reporting step count, peak value and termination cause.
// Ports: clk, rst (async, active-high), start/seed (run request),
//        busy, done (1-cycle pulse), x, steps, peak, ovf, tmo, err.
// Macro COLLATZ_SHORTCUT_EN (in collatz_step) folds odd steps into one cycle.
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x,
    output logic [STEPW-1:0] steps,
    output logic [WIDTH-1:0] peak,
    output logic             ovf,
    output logic             tmo,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [STEPW-1:0] r_steps;
    logic [WIDTH-1:0] r_peak;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic             r_tmo;
    logic             r_err;

    logic [WIDTH-1:0] w_next;
    logic [1:0]       w_inc;
    logic             w_step_ovf;
    logic [STEPW:0]   w_sum;
    logic [WIDTH-1:0] w_peak_next;
    cause_t           w_cause;

    collatz_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_x    (r_x),
        .o_next (w_next),
        .o_inc  (w_inc),
        .o_ovf  (w_step_ovf)
    );

    // Extra top bit flags a step count past the saturation limit.
    assign w_sum       = {1'b0, r_steps} + (STEPW+1)'(w_inc);
    assign w_peak_next = (w_next > r_peak) ? w_next : r_peak;

    // Termination checks in priority order.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (r_x == '0)
            w_cause = CAUSE_ERR;
        else if (r_x == WIDTH'(1))
            w_cause = CAUSE_ONE;
        else if (w_step_ovf)
            w_cause = CAUSE_OVF;
        else if (w_sum[STEPW])
            w_cause = CAUSE_TMO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_steps <= '0;
            r_peak  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= seed;
                        r_steps <= '0;
                        r_peak  <= seed;
                        r_ovf   <= 1'b0;
                        r_tmo   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_cause == CAUSE_NONE) begin
                        r_x     <= w_next;
                        r_steps <= w_sum[STEPW-1:0];
                        r_peak  <= w_peak_next;
                    end else begin
                        r_err   <= (w_cause == CAUSE_ERR);
                        r_ovf   <= (w_cause == CAUSE_OVF);
                        r_tmo   <= (w_cause == CAUSE_TMO);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign x     = r_x;
    assign steps = r_steps;
    assign peak  = r_peak;
    assign ovf   = r_ovf;
    assign tmo   = r_tmo;
    assign err   = r_err;

endmodule

// File: tb/tb_collatz_engine.sv
// Bench for collatz_engine: three instances (16/16, 8/16, 16/4 bits),
// expected results queued at start and compared when done pulses.
module tb_collatz_engine;

    typedef struct {
        string  tag;
        longint x;
        longint steps;
        longint peak;
        bit     ovf;
        bit     tmo;
        bit     err;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [3];
    logic [15:0] sd [3];

    logic        b0, d0, o0, t0, e0;
    logic [15:0] x0, s0, p0;
    logic        b1, d1, o1, t1, e1;
    logic [7:0]  x1, p1;
    logic [15:0] s1;
    logic        b2, d2, o2, t2, e2;
    logic [15:0] x2, p2;
    logic [3:0]  s2;

    collatz_engine #(.WIDTH(16), .STEPW(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .seed(sd[0]),
        .busy(b0), .done(d0), .x(x0), .steps(s0), .peak(p0),
        .ovf(o0), .tmo(t0), .err(e0)
    );

    collatz_engine #(.WIDTH(8), .STEPW(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .seed(sd[1][7:0]),
        .busy(b1), .done(d1), .x(x1), .steps(s1), .peak(p1),
        .ovf(o1), .tmo(t1), .err(e1)
    );

    collatz_engine #(.WIDTH(16), .STEPW(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .seed(sd[2]),
        .busy(b2), .done(d2), .x(x2), .steps(s2), .peak(p2),
        .ovf(o2), .tmo(t2), .err(e2)
    );

    logic        m_busy [3];
    logic        m_done [3];
    logic        m_ovf  [3];
    logic        m_tmo  [3];
    logic        m_err  [3];
    logic [15:0] m_x    [3];
    logic [15:0] m_stp  [3];
    logic [15:0] m_peak [3];

    always_comb begin
        m_busy[0] = b0; m_done[0] = d0; m_ovf[0] = o0;
        m_tmo[0]  = t0; m_err[0]  = e0;
        m_x[0] = x0; m_stp[0] = s0; m_peak[0] = p0;
        m_busy[1] = b1; m_done[1] = d1; m_ovf[1] = o1;
        m_tmo[1]  = t1; m_err[1]  = e1;
        m_x[1] = {8'h00, x1}; m_stp[1] = s1; m_peak[1] = {8'h00, p1};
        m_busy[2] = b2; m_done[2] = d2; m_ovf[2] = o2;
        m_tmo[2]  = t2; m_err[2]  = e2;
        m_x[2] = x2; m_stp[2] = {12'h000, s2}; m_peak[2] = p2;
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of a run: iterate until a termination cause.
    function automatic exp_t model(input int w, input int sw, input longint sv);
        exp_t   e;
        longint xv, nx, mx, ms;
        int     inc;
        bit     fin;
        mx = (longint'(1) << w) - 1;
        ms = (longint'(1) << sw) - 1;
        xv = sv;
        e.tag = ""; e.steps = 0; e.peak = sv;
        e.ovf = 0; e.tmo = 0; e.err = 0; e.cyc = 0;
        fin = 0;
        while (!fin) begin
            e.cyc++;
            if (xv == 0) begin
                e.err = 1; fin = 1;
            end else if (xv == 1) begin
                fin = 1;
            end else begin
                if (xv % 2 == 0) begin
                    nx = xv / 2; inc = 1;
                end else begin
`ifdef COLLATZ_SHORTCUT_EN
                    nx = (3 * xv + 1) / 2; inc = 2;
`else
                    nx = 3 * xv + 1; inc = 1;
`endif
                end
                if (nx > mx) begin
                    e.ovf = 1; fin = 1;
                end else if (e.steps + inc > ms) begin
                    e.tmo = 1; fin = 1;
                end else begin
                    xv = nx;
                    e.steps += inc;
                    if (nx > e.peak) e.peak = nx;
                end
            end
        end
        e.x = xv;
        return e;
    endfunction

    task automatic run(input int idx, input longint sv, input string tag,
                       input bit poke, output int cyc);
        exp_t e;
        int   c;
        bit   got;
        int   w;
        int   sw;
        w  = (idx == 1) ? 8 : 16;
        sw = (idx == 2) ? 4 : 16;
        e = model(w, sw, sv);
        e.tag = tag;
        sb.push_back(e);
        sd[idx] = 16'(sv);
        st[idx] = 1'b1;
        @(posedge clk);
        #1 st[idx] = 1'b0;
        chk({tag, "_busy_e0"}, m_busy[idx], 1);
        got = 0;
        c = 0;
        while (!got && c < 2000) begin
            if (poke && c == 20) begin
                st[idx] = 1'b1;
                sd[idx] = 16'd7;
            end
            @(posedge clk);
            #1 st[idx] = 1'b0;
            c++;
            if (m_done[idx]) got = 1;
        end
        cyc = c;
        e = sb.pop_front();
        chk({e.tag, "_done_seen"}, got, 1);
        chk({e.tag, "_cycles"}, c, e.cyc);
        chk({e.tag, "_x"}, m_x[idx], e.x);
        chk({e.tag, "_steps"}, m_stp[idx], e.steps);
        chk({e.tag, "_peak"}, m_peak[idx], e.peak);
        chk({e.tag, "_ovf"}, m_ovf[idx], e.ovf);
        chk({e.tag, "_tmo"}, m_tmo[idx], e.tmo);
        chk({e.tag, "_err"}, m_err[idx], e.err);
        chk({e.tag, "_busy_low"}, m_busy[idx], 0);
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            sd[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x0, 0);
        chk("rst_steps", s0, 0);
        chk("rst_peak", p0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_done", d0, 0);
        chk("rst_flags", {o0, t0, e0}, 0);
        @(negedge clk);
        rst = 1'b0;

        run(0, 6, "s6", 0, cyc);
`ifdef COLLATZ_SHORTCUT_EN
        chk("s6_edge", cyc, 7);
`else
        chk("s6_edge", cyc, 9);
        chk("s6_peak_c", p0, 16);
`endif
        chk("s6_steps_c", s0, 8);
        chk("s6_x_c", x0, 1);

        run(0, 27, "s27", 1, cyc);
        chk("s27_steps_c", s0, 111);
`ifndef COLLATZ_SHORTCUT_EN
        chk("s27_peak_c", p0, 9232);
`endif

        run(1, 255, "o255", 0, cyc);
        chk("o255_edge", cyc, 1);
        chk("o255_ovf_c", o1, 1);
        chk("o255_x_c", x1, 255);
        chk("o255_steps_c", s1, 0);

        run(2, 27, "t27", 0, cyc);
        chk("t27_tmo_c", t2, 1);

        run(0, 0, "z0", 0, cyc);
        chk("z0_edge", cyc, 1);
        run(0, 1, "one", 0, cyc);
        chk("one_edge", cyc, 1);
        @(posedge clk);
        #1 chk("done_pulse_fall", d0, 0);

        sd[0] = 16'd27;
        st[0] = 1'b1;
        @(posedge clk);
        #1 st[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_x", x0, 0);
        chk("mrst_steps", s0, 0);
        chk("mrst_peak", p0, 0);
        chk("mrst_busy", b0, 0);
        chk("mrst_flags", {d0, o0, t0, e0}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 6, "rs6", 0, cyc);

        for (int i = 0; i < 4; i++) begin
            run(0, longint'($urandom_range(2, 3000)), "rnd", 0, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
